// File: rtl/serial_pattern_tx.sv
// Serial frame transmitter: preamble, data word MSB-first, then idle-zero gap,
// one bit per clock on a registered q line, with a load/ready handshake.
module serial_pattern_tx #(
    parameter int                 WIDTH   = 8,
    parameter int                 PRE_LEN = 4,
    parameter logic [PRE_LEN-1:0] PRE_PAT = 4'b1001,
    parameter int                 GAP     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             q,
    output logic             busy,
    output logic             done
);

    localparam int MAX_LEN  = (PRE_LEN > WIDTH) ? ((PRE_LEN > GAP) ? PRE_LEN : GAP)
                                                : ((WIDTH > GAP) ? WIDTH : GAP);
    localparam int CW       = $clog2(MAX_LEN + 1);
    localparam int FW       = PRE_LEN + WIDTH;
    localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_DATA,
        S_GAP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [FW-1:0]   frame_q, frame_d;
    logic            q_q, q_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;

    // Preamble and data share one shift register, so q is always its MSB
    // while a frame is on the wire; the counter only measures phase lengths.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (load) begin
                    state_d = S_PRE;
                    cnt_d   = '0;
                    frame_d = {PRE_PAT, din};
                end
            end
            S_PRE: begin
                frame_d = frame_q << 1;
                if (cnt_q == CW'(PRE_LEN - 1)) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                frame_d = frame_q << 1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d = '0;
                    if (GAP == 0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(GAP_LAST)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are derived from the next state so they register alongside it.
        q_d     = ((state_d == S_PRE) || (state_d == S_DATA)) ? frame_d[FW-1] : 1'b0;
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            frame_q <= '0;
            q_q     <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            frame_q <= frame_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign q     = q_q;
    assign busy  = busy_q;
    assign ready = ready_q;
    assign done  = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: a default instance and a WIDTH=1/GAP=0 corner
// instance, both checked every cycle against a frame-queue reference model.
module tb_serial_pattern_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din0;
    logic       ld0;
    logic       q0, busy0, ready0, done0;
    logic [0:0] din1;
    logic       ld1;
    logic       q1, busy1, ready1, done1;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the remaining bits of the frame on the wire.
    bit exp_bits [2][0:15];
    int exp_len  [2];
    int exp_pos  [2];
    bit exp_done [2];

    always #5 clk = ~clk;

    serial_pattern_tx dut0 (
        .clk   (clk),
        .reset (reset),
        .din   (din0),
        .load  (ld0),
        .ready (ready0),
        .q     (q0),
        .busy  (busy0),
        .done  (done0)
    );

    serial_pattern_tx #(.WIDTH(1), .GAP(0)) dut1 (
        .clk   (clk),
        .reset (reset),
        .din   (din1),
        .load  (ld1),
        .ready (ready1),
        .q     (q1),
        .busy  (busy1),
        .done  (done1)
    );

    task automatic check(input string tag, input logic got, input logic want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_edge(input int d, input bit rst, input bit ld, input logic [7:0] dv);
        int         w;
        int         g;
        logic [3:0] pre;
        pre = 4'b1001;
        w   = (d == 0) ? 8 : 1;
        g   = (d == 0) ? 2 : 0;
        if (rst) begin
            exp_len[d]  = 0;
            exp_pos[d]  = 0;
            exp_done[d] = 1'b0;
        end else if (exp_pos[d] < exp_len[d]) begin
            exp_pos[d]  = exp_pos[d] + 1;
            exp_done[d] = (exp_pos[d] == exp_len[d]);
            if (exp_done[d]) begin
                exp_len[d] = 0;
                exp_pos[d] = 0;
            end
        end else begin
            exp_done[d] = 1'b0;
            if (ld) begin
                for (int i = 0; i < 4; i++) exp_bits[d][i] = pre[3-i];
                for (int i = 0; i < w; i++) exp_bits[d][4+i] = dv[w-1-i];
                for (int i = 0; i < g; i++) exp_bits[d][4+w+i] = 1'b0;
                exp_len[d] = 4 + w + g;
                exp_pos[d] = 0;
            end
        end
    endtask

    task automatic check_dut(input int d, input logic q, input logic busy,
                             input logic ready, input logic done);
        bit active;
        active = (exp_pos[d] < exp_len[d]);
        check($sformatf("dut%0d.q", d),     q,     active ? exp_bits[d][exp_pos[d]] : 1'b0);
        check($sformatf("dut%0d.busy", d),  busy,  active);
        check($sformatf("dut%0d.ready", d), ready, !active);
        check($sformatf("dut%0d.done", d),  done,  exp_done[d]);
    endtask

    task automatic step(input bit rst, input bit l0, input logic [7:0] d0,
                        input bit l1, input logic [0:0] d1);
        reset = rst;
        ld0   = l0;
        din0  = d0;
        ld1   = l1;
        din1  = d1;
        @(posedge clk);
        #1;
        model_edge(0, rst, l0, d0);
        model_edge(1, rst, l1, {7'b0, d1});
        check_dut(0, q0, busy0, ready0, done0);
        check_dut(1, q1, busy1, ready1, done1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, 1'b0, 1'b0);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            exp_len[d]  = 0;
            exp_pos[d]  = 0;
            exp_done[d] = 1'b0;
        end

        // Reset then idle; load during reset must be ignored.
        step(1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(5);

        // Single default frame A5; corner instance sends din=1.
        step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1);
        idle(17);

        // Back-to-back: second load lands in the done cycle.
        step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        idle(14);
        step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        idle(17);

        // Load pulsed mid-frame is ignored.
        step(1'b0, 1'b1, 8'hC3, 1'b1, 1'b0);
        idle(4);
        step(1'b0, 1'b1, 8'h3C, 1'b1, 1'b1);
        idle(20);

        // Reset during the third data bit, then a fresh frame.
        step(1'b0, 1'b1, 8'h96, 1'b0, 1'b0);
        idle(6);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        idle(4);
        step(1'b0, 1'b1, 8'h6B, 1'b1, 1'b1);
        idle(17);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 3) == 0), 8'($urandom),
                 ($urandom_range(0, 2) == 0), 1'($urandom));
        end
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial frame transmitter that drives the single-bit `q` line consumed by the team's Moore sequence detector. It accepts a parallel data word through a load/ready handshake. It then emits a fixed preamble, the data word MSB-first, and a run of idle zeros, one bit per clock. It is the sending end of the serial pattern link and is used both in benches and in loopback configurations against the detector.

## Interface
- `WIDTH`, 8, data word width in bits (≥1).
- `PRE_LEN`, 4, preamble length in bits (≥1).
- `PRE_PAT`, 4'b1001, preamble pattern, `PRE_LEN` bits wide, sent MSB-first.
- `GAP`, 2, number of trailing idle-zero bits per frame (≥0).

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `din`  in  WIDTH  data word; sampled only on an accepted load.
- `load`  in  1  request to start a frame; ignored unless `ready`=1.
- `ready`  out  1  high only in IDLE; the block can accept a frame.
- `q`  out  1  registered serial output bit.
- `busy`  out  1  high while `q` carries preamble, data, or gap bits.
- `done`  out  1  one-cycle pulse on the first IDLE cycle after a completed frame.

## Operation
- State machine states: IDLE, PRE, DATA, GAP.
- IDLE:
  - `q`=0, `busy`=0, `ready`=1.
  - On `load`=1 at a rising edge: latch `din` into the shift register, set bit counter to 0, go to PRE.
- PRE:
  - `q` = `PRE_PAT[PRE_LEN-1-cnt]`.
  - After `PRE_LEN` bits, go to DATA with the counter cleared.
- DATA:
  - `q` = shift register MSB; the register shifts left by one each cycle.
  - After `WIDTH` bits, go to GAP. If `GAP`=0, go directly to IDLE.
- GAP:
  - `q`=0, `busy`=1.
  - After `GAP` cycles, go to IDLE and assert `done` for exactly that first IDLE cycle.
- Counter: unsigned, sized $clog2(max(PRE_LEN,WIDTH,GAP)+1). It clears on every state change and never wraps within a state.
- `done` is produced only by normal frame completion. Reset never produces `done`.
- `load` while `ready`=0 is ignored and is not queued. `din` changes outside an accepted load have no effect.
- Reset (sync): on the first rising edge with `reset`=1, the block enters IDLE with:
  - `q`=0, `busy`=0, `ready`=1, `done`=0.
  - Shift register and counter = 0.
  - `load` is ignored while `reset`=1.
- Reset mid-frame: the frame is aborted at that edge, `q` returns to 0, no `done` is produced, and no further frame bits are emitted.
- Simultaneous `load` and `done`: this is legal. `done`=1 coincides with `ready`=1, so a load in that cycle is accepted and the next frame starts on the following cycle.

## Timing
- All outputs are registered and change only on a rising edge of `clk`.
- Load accepted at edge N: the first preamble bit appears on `q` after edge N and holds for cycle N+1. `busy`=1 and `ready`=0 from the same edge.
- Frame length: F = `PRE_LEN`+`WIDTH`+`GAP` cycles of `busy`=1, each holding one bit.
- `done` is high in cycle N+F+1, together with `ready`=1.
- Minimum accepted-load spacing is F+1 cycles, giving throughput of one frame per F+1 cycles.
- `q` is stable for the whole cycle, so the detector samples it on the next rising edge.

## Test plan
- Reset then idle: hold `reset`=1 for 2 cycles, then release; keep `load`=0 for 5 cycles → every cycle shows `q`=0, `busy`=0, `ready`=1, `done`=0.
- Single frame with defaults: load `din`=8'hA5 → `q` over 14 cycles = 1,0,0,1, 1,0,1,0,0,1,0,1, 0,0. `busy`=1 for exactly those 14 cycles, and `done`=1 for one cycle after them.
- Back-to-back frames: load 8'hFF, then assert `load` with `din`=8'h00 in the `done` cycle → the second frame's preamble starts on the next cycle, with no extra idle cycle. The second frame's data bits are all 0.
- Ignored load: pulse `load` with `din`=8'h3C at cycle 5 of a frame started with 8'hC3 → the frame still sends 8'hC3, and no second frame follows.
- Reset mid-frame: assert `reset` during the 3rd data bit → `q`=0, `busy`=0, `ready`=1 after that edge, no `done` appears, and a new load afterwards sends a complete frame.
- Parameter corner: `GAP`=0, `WIDTH`=1, `din`=1 → `q` = 1,0,0,1,1 over 5 busy cycles, then `done` immediately follows.
